// File: rtl/jtmitchell_busctl.sv
// jtmitchell_busctl: Z80 bus controller for the Mitchell-family main CPU.
// Decodes memory and I/O cycles, forms the banked ROM byte address, stalls
// the CPU through cpu_cen while SDRAM ROM data is fetched, generates the
// VBLANK interrupt and holds the video/sound/EEPROM control latches.
//
// Wait FSM:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | CPU running; a ROM access to a new address starts a fetch
//   ST_STALE | one clk in which rom_ok may still refer to the old address
//   ST_WAIT  | waiting for rom_ok; on it, the address is recorded as served

module jtmitchell_busctl #(
    parameter int BANK_W    = 4,
    parameter int BANK_BASE = 2,
    parameter int ROM_AW    = 20,
    parameter int INT_CLR   = 1,
    parameter int INT_LEN   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    output logic              cpu_cen,
    input  logic [15:0]       A,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              m1_n,
    input  logic              rfsh_n,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    input  logic              LVBL,
    output logic              int_n,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_cs,
    input  logic [7:0]        rom_data,
    input  logic              rom_ok,
    output logic              ram_cs,
    output logic              pal_cs,
    output logic              attr_cs,
    output logic              vram_cs,
    input  logic [7:0]        ram_dout,
    input  logic [7:0]        pal_dout,
    input  logic [7:0]        attr_dout,
    input  logic [7:0]        vram_dout,
    input  logic [7:0]        fm_dout,
    input  logic [7:0]        pcm_dout,
    input  logic [7:0]        cab_dout,
    input  logic [7:0]        sys_dout,
    output logic              fm_cs,
    output logic              pcm_cs,
    output logic              cab_cs,
    output logic              sys_cs,
    output logic [1:0]        cab_sel,
    output logic              dma_go,
    output logic              flip,
    output logic              video_enb,
    output logic              pcm_bank,
    output logic              pal_bank,
    output logic              char_en,
    output logic              obj_en,
    output logic              vram_msb,
    output logic [BANK_W-1:0] bank,
    output logic              scs,
    output logic              sclk,
    output logic              sdi
);

    localparam int CNT_W = $clog2(INT_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALE = 2'd1,
        ST_WAIT  = 2'd2
    } wait_state_t;

    wait_state_t        state_q;
    wait_state_t        state_d;

    logic               mem_act;
    logic               rom_lo;
    logic               rom_hi;
    logic [ROM_AW-1:0]  bank_page;
    logic [ROM_AW-1:0]  banked_addr;
    logic [ROM_AW-1:0]  direct_addr;

    logic               io_act;
    logic               io_wr;
    logic               io_rd;
    logic [4:0]         port;
    logic               dma_dec;
    logic               dma_done;

    logic [ROM_AW-1:0]  last_addr;
    logic               last_valid;
    logic               addr_changed;
    logic               need_wait;
    logic               serve_done;

    logic               lvbl_l;
    logic               lvbl_fall;
    logic [CNT_W-1:0]   int_cnt;

    // Memory decode: only real memory cycles count, refresh cycles are ignored
    always_comb begin
        mem_act = !mreq_n && rfsh_n;
        rom_lo  = mem_act && !A[15];
        rom_hi  = mem_act && (A[15:14] == 2'b10);
        rom_cs  = rom_lo || rom_hi;
        pal_cs  = mem_act && (A[15:11] == 5'b11000);
        attr_cs = mem_act && (A[15:11] == 5'b11001);
        vram_cs = mem_act && (A[15:12] == 4'hD);
        ram_cs  = mem_act && (A[15:13] == 3'b111);
    end

    // ROM address: fixed lower 32kB, banked 16kB window above; the banked
    // page is computed at ROM_AW bits so oversize banks simply wrap
    always_comb begin
        bank_page   = ROM_AW'(BANK_BASE) + ROM_AW'(bank);
        banked_addr = (bank_page << 14) | ROM_AW'(A[13:0]);
        direct_addr = ROM_AW'(A[14:0]);
        rom_addr    = rom_hi ? banked_addr : direct_addr;
    end

    // I/O decode on A[4:0]; interrupt-acknowledge cycles (m1_n low) excluded
    always_comb begin
        io_act  = !iorq_n && m1_n;
        io_wr   = io_act && !wr_n;
        io_rd   = io_act && !rd_n;
        port    = A[4:0];
        fm_cs   = (io_wr || io_rd) && ((port == 5'h03) || (port == 5'h04));
        pcm_cs  = io_wr && (port == 5'h05);
        cab_cs  = io_rd && (port <= 5'h02);
        sys_cs  = io_rd && (port == 5'h05);
        cab_sel = A[1:0];
        dma_dec = io_act && (port == 5'h06);
        dma_go  = !rst && dma_dec && !dma_done;
    end

    // DMA trigger is one-shot per I/O cycle; re-armed once iorq_n releases
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dma_done <= 1'b0;
        end else if (iorq_n) begin
            dma_done <= 1'b0;
        end else if (dma_dec) begin
            dma_done <= 1'b1;
        end
    end

    // Control latches follow the write decode level on every clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flip      <= 1'b0;
            video_enb <= 1'b0;
            pcm_bank  <= 1'b0;
            pal_bank  <= 1'b0;
            char_en   <= 1'b1;
            obj_en    <= 1'b1;
            vram_msb  <= 1'b0;
            bank      <= '0;
            scs       <= 1'b0;
            sclk      <= 1'b0;
            sdi       <= 1'b0;
        end else if (io_wr) begin
            case (port)
                5'h00: begin
                    flip      <= cpu_dout[2];
                    video_enb <= cpu_dout[3];
                    pcm_bank  <= cpu_dout[4];
                    pal_bank  <= cpu_dout[5];
                    char_en   <= cpu_dout[6];
                    obj_en    <= cpu_dout[7];
                end
                5'h02:   bank     <= cpu_dout[BANK_W-1:0];
                5'h07:   vram_msb <= cpu_dout[0];
                5'h08:   scs      <= cpu_dout[7];
                5'h10:   sclk     <= cpu_dout[7];
                5'h18:   sdi      <= cpu_dout[7];
                default: ;
            endcase
        end
    end

    // Read data mux, registered; ROM has top priority, open bus reads FF
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_din <= 8'hFF;
        end else if (rom_cs) begin
            cpu_din <= rom_data;
        end else if (ram_cs) begin
            cpu_din <= ram_dout;
        end else if (pal_cs) begin
            cpu_din <= pal_dout;
        end else if (attr_cs) begin
            cpu_din <= attr_dout;
        end else if (vram_cs) begin
            cpu_din <= vram_dout;
        end else if (fm_cs) begin
            cpu_din <= fm_dout;
        end else if (pcm_cs) begin
            cpu_din <= pcm_dout;
        end else if (sys_cs) begin
            cpu_din <= sys_dout;
        end else if (cab_cs) begin
            cpu_din <= cab_dout;
        end else begin
            cpu_din <= 8'hFF;
        end
    end

    // A fetch is needed whenever the ROM address differs from the last one
    // served; after reset nothing has been served, so the first fetch waits
    always_comb begin
        addr_changed = !last_valid || (rom_addr != last_addr);
        need_wait    = rom_cs && addr_changed;
    end

    // Wait FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Wait FSM next state; STALE skips one clk so an old rom_ok is ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (need_wait) state_d = ST_STALE;
            ST_STALE: state_d = ST_WAIT;
            ST_WAIT:  if (rom_ok) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Wait FSM outputs: CPU advances only when idle and not starting a fetch
    always_comb begin
        cpu_cen    = !rst && cen && (state_q == ST_IDLE) && !need_wait;
        serve_done = (state_q == ST_WAIT) && rom_ok;
    end

    // Remember which ROM address the SDRAM data currently belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_addr  <= '0;
            last_valid <= 1'b0;
        end else if (serve_done) begin
            last_addr  <= rom_addr;
            last_valid <= 1'b1;
        end
    end

    // LVBL sampled for falling-edge detection; resets low to avoid a
    // spurious interrupt when reset is released during blanking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvbl_l <= 1'b0;
        end else begin
            lvbl_l <= LVBL;
        end
    end

    assign lvbl_fall = lvbl_l && !LVBL;

    // Interrupt: a new VBLANK edge always wins over acknowledge/timeout and
    // restarts the pulse counter rather than queueing a second interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_n   <= 1'b1;
            int_cnt <= '0;
        end else if (lvbl_fall) begin
            int_n   <= 1'b0;
            int_cnt <= CNT_W'(INT_LEN);
        end else if (!int_n) begin
            if (INT_CLR != 0) begin
                if (!m1_n && !iorq_n) int_n <= 1'b1;
            end else if (cen) begin
                if (int_cnt <= CNT_W'(1)) int_n <= 1'b1;
                int_cnt <= int_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_jtmitchell_busctl.sv
// Self-checking bench for jtmitchell_busctl: a decode/read-mux vector table
// plus directed sequences for wait states, banking, latches, interrupt,
// DMA trigger and reset during a ROM wait. A second instance uses
// ROM_AW=17 and INT_CLR=0 for address wrap and timed interrupt release.

module tb_jtmitchell_busctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic [15:0] A = 16'h0000;
    logic        mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic        m1_n = 1'b1, rfsh_n = 1'b1;
    logic [7:0]  cpu_dout = 8'h00;
    logic        LVBL = 1'b1;
    logic [7:0]  rom_data = 8'hA5;
    logic        rom_ok = 1'b1;
    logic [7:0]  ram_dout = 8'h11, pal_dout = 8'h22, attr_dout = 8'h33, vram_dout = 8'h44;
    logic [7:0]  fm_dout = 8'h55, pcm_dout = 8'h66, cab_dout = 8'h77, sys_dout = 8'h88;

    logic        cpu_cen, int_n, rom_cs, ram_cs, pal_cs, attr_cs, vram_cs;
    logic        fm_cs, pcm_cs, cab_cs, sys_cs, dma_go;
    logic        flip, video_enb, pcm_bank, pal_bank, char_en, obj_en, vram_msb;
    logic        scs, sclk, sdi;
    logic [7:0]  cpu_din;
    logic [19:0] rom_addr;
    logic [1:0]  cab_sel;
    logic [3:0]  bank;

    logic        b_cpu_cen, b_int_n, b_rom_cs, b_ram_cs, b_pal_cs, b_attr_cs, b_vram_cs;
    logic        b_fm_cs, b_pcm_cs, b_cab_cs, b_sys_cs, b_dma_go;
    logic        b_flip, b_video_enb, b_pcm_bank, b_pal_bank, b_char_en, b_obj_en, b_vram_msb;
    logic        b_scs, b_sclk, b_sdi;
    logic [7:0]  b_cpu_din;
    logic [16:0] b_rom_addr;
    logic [1:0]  b_cab_sel;
    logic [3:0]  b_bank;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    jtmitchell_busctl dut (
        .clk(clk), .rst(rst), .cen(cen), .cpu_cen(cpu_cen), .A(A),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n),
        .cpu_dout(cpu_dout), .cpu_din(cpu_din), .LVBL(LVBL), .int_n(int_n),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
        .ram_cs(ram_cs), .pal_cs(pal_cs), .attr_cs(attr_cs), .vram_cs(vram_cs),
        .ram_dout(ram_dout), .pal_dout(pal_dout), .attr_dout(attr_dout), .vram_dout(vram_dout),
        .fm_dout(fm_dout), .pcm_dout(pcm_dout), .cab_dout(cab_dout), .sys_dout(sys_dout),
        .fm_cs(fm_cs), .pcm_cs(pcm_cs), .cab_cs(cab_cs), .sys_cs(sys_cs), .cab_sel(cab_sel),
        .dma_go(dma_go), .flip(flip), .video_enb(video_enb), .pcm_bank(pcm_bank),
        .pal_bank(pal_bank), .char_en(char_en), .obj_en(obj_en), .vram_msb(vram_msb),
        .bank(bank), .scs(scs), .sclk(sclk), .sdi(sdi)
    );

    jtmitchell_busctl #(.ROM_AW(17), .INT_CLR(0)) dut2 (
        .clk(clk), .rst(rst), .cen(cen), .cpu_cen(b_cpu_cen), .A(A),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n),
        .cpu_dout(cpu_dout), .cpu_din(b_cpu_din), .LVBL(LVBL), .int_n(b_int_n),
        .rom_addr(b_rom_addr), .rom_cs(b_rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
        .ram_cs(b_ram_cs), .pal_cs(b_pal_cs), .attr_cs(b_attr_cs), .vram_cs(b_vram_cs),
        .ram_dout(ram_dout), .pal_dout(pal_dout), .attr_dout(attr_dout), .vram_dout(vram_dout),
        .fm_dout(fm_dout), .pcm_dout(pcm_dout), .cab_dout(cab_dout), .sys_dout(sys_dout),
        .fm_cs(b_fm_cs), .pcm_cs(b_pcm_cs), .cab_cs(b_cab_cs), .sys_cs(b_sys_cs), .cab_sel(b_cab_sel),
        .dma_go(b_dma_go), .flip(b_flip), .video_enb(b_video_enb), .pcm_bank(b_pcm_bank),
        .pal_bank(b_pal_bank), .char_en(b_char_en), .obj_en(b_obj_en), .vram_msb(b_vram_msb),
        .bank(b_bank), .scs(b_scs), .sclk(b_sclk), .sdi(b_sdi)
    );

    typedef struct {
        logic [15:0] a;
        logic        mem;
        logic        io;
        logic        rd;
        logic        wr;
        logic        m1_n;
        logic        rfsh_n;
        logic [19:0] exp_addr;
        logic [8:0]  exp_sel;   // {rom,ram,pal,attr,vram,fm,pcm,cab,sys}
        logic [7:0]  exp_din;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h, want %0h", name, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        m1_n = 1'b1; rfsh_n = 1'b1; cpu_dout = 8'h00;
    endtask

    task automatic mem_rd(input logic [15:0] addr);
        bus_idle();
        A = addr; mreq_n = 1'b0; rd_n = 1'b0;
    endtask

    task automatic io_wr(input logic [15:0] addr, input logic [7:0] data);
        bus_idle();
        A = addr; iorq_n = 1'b0; wr_n = 1'b0; cpu_dout = data;
    endtask

    // Number of consecutive samples (one per clk) with cpu_cen low, bounded
    task automatic count_low(output int n);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (cpu_cen) break;
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        // address, mem, io, rd, wr, m1_n, rfsh_n, exp_addr, exp_sel, exp_din (bank = 0)
        vecs[0]  = '{16'h1234, 1, 0, 1, 0, 1, 1, 20'h01234, 9'h100, 8'hA5};
        vecs[1]  = '{16'h9ABC, 1, 0, 1, 0, 1, 1, 20'h09ABC, 9'h100, 8'hA5};
        vecs[2]  = '{16'hBFFF, 1, 0, 1, 0, 1, 1, 20'h0BFFF, 9'h100, 8'hA5};
        vecs[3]  = '{16'hC100, 1, 0, 1, 0, 1, 1, 20'h0,     9'h040, 8'h22};
        vecs[4]  = '{16'hC7FF, 1, 0, 1, 0, 1, 1, 20'h0,     9'h040, 8'h22};
        vecs[5]  = '{16'hC800, 1, 0, 1, 0, 1, 1, 20'h0,     9'h020, 8'h33};
        vecs[6]  = '{16'hD555, 1, 0, 1, 0, 1, 1, 20'h0,     9'h010, 8'h44};
        vecs[7]  = '{16'hE001, 1, 0, 1, 0, 1, 1, 20'h0,     9'h080, 8'h11};
        vecs[8]  = '{16'hFFFF, 1, 0, 1, 0, 1, 1, 20'h0,     9'h080, 8'h11};
        vecs[9]  = '{16'h1234, 1, 0, 1, 0, 1, 0, 20'h0,     9'h000, 8'hFF};
        vecs[10] = '{16'h0000, 0, 1, 1, 0, 1, 1, 20'h0,     9'h002, 8'h77};
        vecs[11] = '{16'h0002, 0, 1, 1, 0, 1, 1, 20'h0,     9'h002, 8'h77};
        vecs[12] = '{16'h0005, 0, 1, 1, 0, 1, 1, 20'h0,     9'h001, 8'h88};
        vecs[13] = '{16'h0003, 0, 1, 1, 0, 1, 1, 20'h0,     9'h008, 8'h55};
        vecs[14] = '{16'h0004, 0, 1, 0, 1, 1, 1, 20'h0,     9'h008, 8'h55};
        vecs[15] = '{16'h0005, 0, 1, 0, 1, 1, 1, 20'h0,     9'h004, 8'h66};
        vecs[16] = '{16'h0000, 0, 1, 1, 0, 0, 1, 20'h0,     9'h000, 8'hFF};
        vecs[17] = '{16'h00E1, 0, 1, 1, 0, 1, 1, 20'h0,     9'h002, 8'h77};

        // Reset values while rst is held (cen high, so cpu_cen must be gated)
        bus_idle();
        tick(); tick();
        chk("rst_cpu_cen", cpu_cen, 0);
        chk("rst_cpu_din", cpu_din, 8'hFF);
        chk("rst_int_n", int_n, 1);
        chk("rst_dma_go", dma_go, 0);
        chk("rst_ctl", {obj_en, char_en, pal_bank, pcm_bank, video_enb, flip, vram_msb}, 7'b1100000);
        chk("rst_bank", bank, 0);
        chk("rst_eeprom", {scs, sclk, sdi}, 0);
        rst = 1'b0;
        tick();

        // First fetch always waits: request clk + STALE + WAIT (rom_ok high)
        mem_rd(16'h0000); #1;
        count_low(n);
        chk("wait_0000", n, 3);
        mem_rd(16'h0001); #1;
        count_low(n);
        chk("wait_0001", n, 3);
        bus_idle(); tick();
        mem_rd(16'h0001); #1;
        chk("no_wait_repeat", cpu_cen, 1);
        bus_idle(); tick();

        // Decode and read-mux table
        foreach (vecs[i]) begin
            bus_idle();
            A      = vecs[i].a;
            mreq_n = !vecs[i].mem;
            iorq_n = !vecs[i].io;
            rd_n   = !vecs[i].rd;
            wr_n   = !vecs[i].wr;
            m1_n   = vecs[i].m1_n;
            rfsh_n = vecs[i].rfsh_n;
            #1;
            chk($sformatf("sel[%0d]", i),
                {rom_cs, ram_cs, pal_cs, attr_cs, vram_cs, fm_cs, pcm_cs, cab_cs, sys_cs},
                vecs[i].exp_sel);
            if (vecs[i].exp_sel[8]) chk($sformatf("addr[%0d]", i), rom_addr, vecs[i].exp_addr);
            if (i == 17) chk("cab_sel", cab_sel, 2'd1);
            tick();
            chk($sformatf("din[%0d]", i), cpu_din, vecs[i].exp_din);
        end
        bus_idle(); tick();

        // Bank 5: (2+5)<<14 | 0x0123; new address stalls even with rom_ok high
        io_wr(16'h0002, 8'h05); tick();
        bus_idle();
        chk("bank5", bank, 4'h5);
        mem_rd(16'h8123); #1;
        chk("addr_bank5", rom_addr, 20'h1C123);
        chk("addr_bank5_17", b_rom_addr, 17'h1C123);
        chk("bank_stall", cpu_cen, 0);
        count_low(n);
        bus_idle(); tick();

        // Bank F: (2+15)<<14 = 0x44000, wraps to 0x04000 at 17 bits
        io_wr(16'h0002, 8'hFF); tick();
        mem_rd(16'h8123); #1;
        chk("addr_bankF", rom_addr, 20'h44123);
        chk("addr_bankF_17", b_rom_addr, 17'h04123);
        count_low(n);
        bus_idle(); tick();

        // Misc, VRAM MSB and EEPROM latches
        io_wr(16'h0000, 8'hC4); tick();
        bus_idle();
        chk("misc_C4", {obj_en, char_en, pal_bank, pcm_bank, video_enb, flip}, 6'b110001);
        io_wr(16'h0007, 8'h01); tick();
        bus_idle();
        chk("vram_msb", vram_msb, 1);
        io_wr(16'h0010, 8'h80); tick();
        bus_idle();
        chk("eeprom_sclk", {scs, sclk, sdi}, 3'b010);
        tick();

        // VBLANK interrupt, acknowledge clear and timed clear
        LVBL = 1'b0; tick();
        chk("int_set", int_n, 0);
        chk("int_set_b", b_int_n, 0);
        cen = 1'b0; tick();
        chk("int_hold", int_n, 0);
        bus_idle(); A = 16'h0000; iorq_n = 1'b0; m1_n = 1'b0; tick();
        bus_idle();
        chk("int_ack", int_n, 1);
        chk("int_ack_ignored_b", b_int_n, 0);
        for (int i = 1; i <= 64; i++) begin
            cen = 1'b1; tick();
            cen = 1'b0;
            if (i == 63) chk("int_len_63", b_int_n, 0);
            tick();
        end
        chk("int_len_64", b_int_n, 1);
        cen = 1'b1;

        // New edge in the same clk as an acknowledge: edge wins
        LVBL = 1'b1; tick();
        LVBL = 1'b0; tick();
        LVBL = 1'b1; tick();
        LVBL = 1'b0; A = 16'h0000; iorq_n = 1'b0; m1_n = 1'b0; tick();
        bus_idle();
        chk("edge_wins", int_n, 0);
        tick();

        // DMA trigger: 5-clk I/O cycle on port 06 gives one pulse
        io_wr(16'h0006, 8'h00); #1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (dma_go) n++;
            tick(); #1;
        end
        bus_idle(); tick();
        chk("dma_pulses", n, 1);
        io_wr(16'h0006, 8'h00); #1;
        chk("dma_rearm", dma_go, 1);
        bus_idle(); tick();

        // Reset in WAIT: everything back to reset state, next fetch waits
        rom_ok = 1'b0;
        mem_rd(16'h0100); tick(); tick(); tick();
        chk("pre_rst_stalled", cpu_cen, 0);
        rst = 1'b1; #1;
        chk("mid_rst_cpu_cen", cpu_cen, 0);
        chk("mid_rst_cpu_din", cpu_din, 8'hFF);
        chk("mid_rst_ctl", {obj_en, char_en, pal_bank, pcm_bank, video_enb, flip, vram_msb}, 7'b1100000);
        chk("mid_rst_bank", bank, 0);
        chk("mid_rst_int_n", int_n, 1);
        tick();
        rst = 1'b0;
        rom_ok = 1'b1;
        #1;
        count_low(n);
        chk("post_rst_wait", n, 3);
        bus_idle(); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
